pixel_fetch_arbiter: RTL and testbench

PIXEL_FETCH_ARBITER -- requirements
Module: pixel_fetch_arbiter

---
 rtl/pixel_fetch_pkg.sv | 23 ++
 rtl/pixel_rr_arb2.sv | 32 +++
 rtl/pixel_fetch_arbiter.sv | 141 ++++++++++++++
 tb/tb_pixel_fetch_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fetch_pkg.sv
// Shared types and constants for the pixel fetch arbiter: FSM states, default
// active-window limits and the flag bit positions in the response word.
package pixel_fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPulse,
    StSettle,
    StCheck,
    StResp
  } state_e;

  localparam int unsigned XMinDefault     = 6;
  localparam int unsigned XMaxDefault     = 637;
  localparam int unsigned XLineEndDefault = 640;

  localparam int unsigned ValidBit   = 24;
  localparam int unsigned TimeoutBit = 31;

  localparam int unsigned RetryW  = 10;
  localparam int unsigned SettleW = 8;

endpackage

// File: rtl/pixel_rr_arb2.sv
// Two-request round-robin arbiter. On a tie the port not granted last wins;
// the last-grant register only moves when the owner strobes update.
module pixel_rr_arb2 (
  input  logic       csi_clk,
  input  logic       rsi_reset_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_port,
  output logic       grant,
  output logic       valid
);

  logic last_q;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= update_port;
    end
  end

  always_comb begin
    valid = |req;
    if (req[0] && req[1]) begin
      grant = ~last_q;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/pixel_fetch_arbiter.sv
// Serves two Avalon-MM read ports from one pixel source: pulses the pixel clock,
// waits for the source to settle, then classifies the column and returns a word.
module pixel_fetch_arbiter
  import pixel_fetch_pkg::*;
#(
  parameter int unsigned X_MIN         = XMinDefault,
  parameter int unsigned X_MAX         = XMaxDefault,
  parameter int unsigned X_LINE_END    = XLineEndDefault,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_RETRY     = 1023
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic [7:0]  coe_c0_red,
  input  logic [7:0]  coe_c1_green,
  input  logic [7:0]  coe_c2_blue,
  input  logic [10:0] coe_c5_x,
  input  logic [10:0] coe_c6_y,
  output logic        coe_c4_requestclock,
  input  logic        avs_s0_read,
  input  logic        avs_s1_read,
  output logic        avs_s0_waitrequest,
  output logic        avs_s1_waitrequest,
  output logic [31:0] avs_s0_readdata,
  output logic [31:0] avs_s1_readdata
);

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic [31:0]         data_q, data_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic                reqclk_q;

  logic        arb_grant, arb_valid, arb_update;
  logic [31:0] x_ext, retry_next;
  logic        x_active, x_legal;
  logic        resp0, resp1;
  logic        unused_y;

  // Row is irrelevant to the window decision.
  assign unused_y = ^coe_c6_y;

  pixel_rr_arb2 u_arb (
    .csi_clk     (csi_clk),
    .rsi_reset_n (rsi_reset_n),
    .req         ({avs_s1_read, avs_s0_read}),
    .update      (arb_update),
    .update_port (grant_q),
    .grant       (arb_grant),
    .valid       (arb_valid)
  );

  assign x_ext      = {21'b0, coe_c5_x};
  assign x_active   = (x_ext >= X_MIN) && (x_ext <= X_MAX);
  assign x_legal    = (x_ext != 32'd0) && (x_ext <= X_LINE_END);
  assign retry_next = {22'b0, retry_q} + 32'd1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    data_d     = data_q;
    retry_d    = retry_q;
    settle_d   = settle_q;
    arb_update = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d  = StPulse;
          grant_d  = arb_grant;
          retry_d  = '0;
          settle_d = SettleW'(SETTLE_CYCLES);
        end
      end
      StPulse: begin
        state_d = (settle_q == '0) ? StCheck : StSettle;
      end
      StSettle: begin
        if (settle_q <= SettleW'(1)) begin
          settle_d = '0;
          state_d  = StCheck;
        end else begin
          settle_d = settle_q - SettleW'(1);
        end
      end
      StCheck: begin
        if (x_active) begin
          data_d           = {8'h00, coe_c0_red, coe_c1_green, coe_c2_blue};
          data_d[ValidBit] = 1'b1;
          state_d          = StResp;
        end else if (x_legal) begin
          data_d  = '0;
          state_d = StResp;
        end else if (retry_next >= MAX_RETRY) begin
          // Counter is left where it is so it can never wrap.
          data_d             = '0;
          data_d[TimeoutBit] = 1'b1;
          state_d            = StResp;
        end else begin
          retry_d  = retry_q + RetryW'(1);
          settle_d = SettleW'(SETTLE_CYCLES);
          state_d  = StPulse;
        end
      end
      StResp: begin
        arb_update = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      data_q   <= '0;
      retry_q  <= '0;
      settle_q <= '0;
      reqclk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
      reqclk_q <= (state_d == StPulse);
    end
  end

  assign coe_c4_requestclock = reqclk_q;

  assign resp0 = (state_q == StResp) && !grant_q;
  assign resp1 = (state_q == StResp) && grant_q;

  assign avs_s0_waitrequest = avs_s0_read && !resp0;
  assign avs_s1_waitrequest = avs_s1_read && !resp1;
  assign avs_s0_readdata    = resp0 ? data_q : 32'h0;
  assign avs_s1_readdata    = resp1 ? data_q : 32'h0;

endmodule

// File: tb/tb_pixel_fetch_arbiter.sv
// Directed bench for pixel_fetch_arbiter: latency, window classification,
// retries, timeout, round-robin ties, dropped reads and mid-transaction reset.
module tb_pixel_fetch_arbiter;

  logic        csi_clk = 1'b0;
  logic        rsi_reset_n = 1'b0;
  logic [7:0]  red = 8'h0, green = 8'h0, blue = 8'h0;
  logic [10:0] x = 11'd0, y = 11'd0;
  logic        reqclk;
  logic        s0_read = 1'b0, s1_read = 1'b0;
  logic        s0_wait, s1_wait;
  logic [31:0] rd0, rd1;

  int checks = 0;
  int failures = 0;

  always #5 csi_clk = ~csi_clk;

  pixel_fetch_arbiter #(
    .MAX_RETRY (4)
  ) dut (
    .csi_clk             (csi_clk),
    .rsi_reset_n         (rsi_reset_n),
    .coe_c0_red          (red),
    .coe_c1_green        (green),
    .coe_c2_blue         (blue),
    .coe_c5_x            (x),
    .coe_c6_y            (y),
    .coe_c4_requestclock (reqclk),
    .avs_s0_read         (s0_read),
    .avs_s1_read         (s1_read),
    .avs_s0_waitrequest  (s0_wait),
    .avs_s1_waitrequest  (s1_wait),
    .avs_s0_readdata     (rd0),
    .avs_s1_readdata     (rd1)
  );

  // Entered and left at posedge+1. Cycle 0 is the cycle the read is raised.
  // x is x_bad for the first n_bad CHECKs, x_good afterwards.
  task automatic do_read(input int port, input logic [10:0] x_bad, input int n_bad,
                         input logic [10:0] x_good, output logic [31:0] data,
                         output logic [31:0] other, output int lat, output int pulses);
    pulses = 0;
    lat    = -1;
    data   = '0;
    other  = '0;
    x = (n_bad > 0) ? x_bad : x_good;
    if (port == 0) s0_read = 1'b1; else s1_read = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge csi_clk);
      if (reqclk) begin
        pulses++;
        x = (pulses <= n_bad) ? x_bad : x_good;
      end
      if ((port == 0) ? !s0_wait : !s1_wait) begin
        data  = (port == 0) ? rd0 : rd1;
        other = (port == 0) ? rd1 : rd0;
        lat   = c;
        @(posedge csi_clk);
        #1;
        break;
      end
      @(posedge csi_clk);
      #1;
    end
    s0_read = 1'b0;
    s1_read = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge csi_clk);
    #1;
    checks++;
    if (reqclk !== 1'b0) begin
      failures++; $display("FAIL reset_reqclk got=%b want=0", reqclk);
    end
    checks++;
    if (s0_wait !== 1'b0 || s1_wait !== 1'b0) begin
      failures++; $display("FAIL reset_wait_idle got=%b%b want=00", s0_wait, s1_wait);
    end
    checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
      failures++; $display("FAIL reset_readdata got=%h/%h want=0/0", rd0, rd1);
    end
    s0_read = 1'b1;
    #1;
    checks++;
    if (s0_wait !== 1'b1) begin
      failures++; $display("FAIL reset_wait_follows_read got=%b want=1", s0_wait);
    end
    s0_read = 1'b0;
    @(posedge csi_clk);
    #1;
    rsi_reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] d, o;
    int lat, p;
    red = 8'h11; green = 8'h22; blue = 8'h33; y = 11'd5;
    do_read(0, 11'd0, 0, 11'd100, d, o, lat, p);
    checks++;
    if (d !== 32'h0111_2233) begin
      failures++; $display("FAIL basic_data got=%h want=01112233", d);
    end
    checks++;
    if (lat != 5) begin
      failures++; $display("FAIL basic_latency got=%0d want=5", lat);
    end
    checks++;
    if (p != 1) begin
      failures++; $display("FAIL basic_pulses got=%0d want=1", p);
    end
    checks++;
    if (o !== 32'h0) begin
      failures++; $display("FAIL basic_other_port_data got=%h want=0", o);
    end
  endtask

  task automatic test_window();
    logic [10:0] xs[8]   = '{11'd3, 11'd639, 11'd6, 11'd637, 11'd5, 11'd638, 11'd640, 11'd1};
    logic [31:0] exps[8] = '{32'h0, 32'h0, 32'h01AA_BBCC, 32'h01AA_BBCC,
                             32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] d, o;
    int lat, p;
    red = 8'hAA; green = 8'hBB; blue = 8'hCC; y = 11'd2000;
    for (int i = 0; i < 8; i++) begin
      do_read(i % 2, 11'd0, 0, xs[i], d, o, lat, p);
      checks++;
      if (d !== exps[i] || lat != 5 || p != 1) begin
        failures++;
        $display("FAIL window_x%0d got=%h lat=%0d pulses=%0d want=%h lat=5 pulses=1",
                 xs[i], d, lat, p, exps[i]);
      end
    end
  endtask

  task automatic test_retry();
    logic [31:0] d, o;
    int lat, p;
    red = 8'h01; green = 8'h02; blue = 8'h03;
    do_read(1, 11'd0, 2, 11'd200, d, o, lat, p);
    checks++;
    if (d !== 32'h0101_0203) begin
      failures++; $display("FAIL retry_data got=%h want=01010203", d);
    end
    checks++;
    if (p != 3 || lat != 13) begin
      failures++; $display("FAIL retry_timing got pulses=%0d lat=%0d want 3/13", p, lat);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d, o;
    int lat, p, idle_p;
    do_read(0, 11'd0, 1000, 11'd0, d, o, lat, p);
    checks++;
    if (d !== 32'h8000_0000) begin
      failures++; $display("FAIL timeout_data got=%h want=80000000", d);
    end
    checks++;
    if (p != 4 || lat != 17) begin
      failures++; $display("FAIL timeout_timing got pulses=%0d lat=%0d want 4/17", p, lat);
    end
    do_read(1, 11'd641, 1000, 11'd641, d, o, lat, p);
    checks++;
    if (d !== 32'h8000_0000 || p != 4) begin
      failures++; $display("FAIL timeout_beyond_line got=%h pulses=%0d want=80000000/4", d, p);
    end
    idle_p = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge csi_clk);
      if (reqclk) idle_p++;
    end
    @(posedge csi_clk);
    #1;
    checks++;
    if (idle_p != 0) begin
      failures++; $display("FAIL timeout_idle_pulses got=%0d want=0", idle_p);
    end
  endtask

  task automatic test_back_to_back();
    int order[4], when[4];
    int exp_when[4] = '{5, 11, 17, 23};
    int n, p;
    logic [31:0] d0;
    n = 0; p = 0; d0 = '0;
    rsi_reset_n = 1'b0;
    #1;
    @(posedge csi_clk);
    #1;
    rsi_reset_n = 1'b1;
    red = 8'h11; green = 8'h22; blue = 8'h33; x = 11'd100;
    s0_read = 1'b1;
    s1_read = 1'b1;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge csi_clk);
      if (reqclk) p++;
      if (!s0_wait) begin
        order[n] = 0; when[n] = c; n++; d0 = rd0;
      end
      if (!s1_wait && n < 4) begin
        order[n] = 1; when[n] = c; n++;
      end
      @(posedge csi_clk);
      #1;
    end
    s0_read = 1'b0;
    s1_read = 1'b0;
    checks++;
    if (n != 4) begin
      failures++; $display("FAIL tie_completions got=%0d want=4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != i % 2 || when[i] != exp_when[i]) begin
          failures++;
          $display("FAIL tie_grant%0d got port=%0d cycle=%0d want port=%0d cycle=%0d",
                   i, order[i], when[i], i % 2, exp_when[i]);
        end
      end
    end
    checks++;
    if (p != 4 || d0 !== 32'h0111_2233) begin
      failures++; $display("FAIL tie_pulses_data got=%0d/%h want=4/01112233", p, d0);
    end
  endtask

  task automatic test_drop();
    int p;
    logic [31:0] d, o;
    int lat, p2;
    p = 0;
    x = 11'd100;
    s0_read = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge csi_clk);
      if (reqclk) p++;
      @(posedge csi_clk);
      #1;
      if (c == 2) s0_read = 1'b0;
    end
    checks++;
    if (p != 1) begin
      failures++; $display("FAIL drop_pulses got=%0d want=1", p);
    end
    red = 8'h44; green = 8'h55; blue = 8'h66;
    do_read(1, 11'd0, 0, 11'd300, d, o, lat, p2);
    checks++;
    if (d !== 32'h0144_5566 || lat != 5 || p2 != 1) begin
      failures++; $display("FAIL drop_next_read got=%h lat=%0d pulses=%0d want=01445566/5/1",
                           d, lat, p2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, o;
    int lat, p, seen;
    seen = 0;
    x = 11'd100;
    red = 8'h11; green = 8'h22; blue = 8'h33;
    s0_read = 1'b1;
    repeat (2) @(posedge csi_clk);
    #2;
    rsi_reset_n = 1'b0;
    #1;
    checks++;
    if (reqclk !== 1'b0 || s0_wait !== 1'b1 || rd0 !== 32'h0) begin
      failures++; $display("FAIL reset_mid_async got reqclk=%b wait=%b rd=%h want 0/1/0",
                           reqclk, s0_wait, rd0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge csi_clk);
      if (reqclk || !s0_wait) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL reset_mid_held got=%0d want=0", seen);
    end
    @(posedge csi_clk);
    #1;
    rsi_reset_n = 1'b1;
    do_read(0, 11'd0, 0, 11'd100, d, o, lat, p);
    checks++;
    if (d !== 32'h0111_2233 || lat != 5 || p != 1) begin
      failures++; $display("FAIL reset_mid_recover got=%h lat=%0d pulses=%0d want=01112233/5/1",
                           d, lat, p);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window();
    test_retry();
    test_timeout();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
